mul_div_unit: RTL and testbench

Multi-cycle RV32M multiply/divide execute unit sitting directly downstream of the ALU control decoder. It consumes the decoder's 11-bit control word, using the mulOp flag and Funct3, together with the two register operands. It runs one iterative 32-step operation with a start/busy/done handshake. The 32-bit result is returned to the execute stage's writeback mux.

---
 rtl/mul_div_unit.sv | 136 +++++++++++++
 tb/tb_mul_div_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. One operation takes a fixed 33 cycles
// from accept to Done: 32 radix-2 steps, then a sign-fix/select cycle.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for Start with mulOp set; Busy low
// S_CALC | 32 shift-add or restoring shift-subtract steps
// S_DONE | sign fix, result select, Done pulse; Result latched on exit
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [10:0]     ControlResult,
  input  logic [XLEN-1:0] OperandA,
  input  logic [XLEN-1:0] OperandB,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q;
  logic [2:0]        f3_q;
  logic              sign_a_q, sign_b_q, div_zero_q;
  logic [XLEN-1:0]   op_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   result_q;

  logic [2:0]        funct3;
  logic              mul_op, accept;
  logic              unsigned_a, unsigned_b, sign_a_in, sign_b_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fixed_result;
  logic              unused_cr;

  assign funct3    = ControlResult[2:0];
  assign mul_op    = ControlResult[6];
  assign unused_cr = ^{ControlResult[10:7], ControlResult[5:3]};
  assign accept    = Start && mul_op && (state_q == S_IDLE);

  // Decode operand signedness and form magnitudes at the accept point.
  always_comb begin
    unsigned_a = (funct3 == 3'b011) || (funct3 == 3'b101) || (funct3 == 3'b111);
    unsigned_b = unsigned_a || (funct3 == 3'b010);
    sign_a_in  = OperandA[XLEN-1] && !unsigned_a;
    sign_b_in  = OperandB[XLEN-1] && !unsigned_b;
    mag_a      = sign_a_in ? (~OperandA + 1'b1) : OperandA;
    mag_b      = sign_b_in ? (~OperandB + 1'b1) : OperandB;
  end

  // One iteration step of each algorithm; the accumulator low half holds the
  // multiplier (shifted out) or the dividend/quotient (shifted through).
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, op_q};
    if (!div_diff[XLEN+1])
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Sign fix and field select; a zero divisor only needs the quotient forced,
  // the remainder path already reproduces the dividend.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = sign_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    fixed_result = prod_fix[XLEN-1:0];
    case (f3_q)
      3'b000:                 fixed_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fixed_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fixed_result = div_zero_q ? '1 : quo_fix;
      default:                fixed_result = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (cnt_q == 5'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch at accept, iterate in CALC, capture result leaving DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      f3_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      op_q       <= '0;
      acc_q      <= '0;
      result_q   <= '0;
    end else if (accept) begin
      cnt_q      <= 5'd31;
      f3_q       <= funct3;
      sign_a_q   <= sign_a_in;
      sign_b_q   <= sign_b_in;
      div_zero_q <= (OperandB == '0);
      op_q       <= funct3[2] ? mag_b : mag_a;
      acc_q      <= {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
    end else if (state_q == S_CALC) begin
      acc_q <= f3_q[2] ? div_next : mul_next;
      if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
    end else if (state_q == S_DONE) begin
      result_q <= fixed_result;
    end
  end

  assign Busy   = (state_q != S_IDLE);
  assign Done   = (state_q == S_DONE);
  assign Result = (state_q == S_DONE) ? fixed_result : result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vectors, handshake/reset corner cases and
// randomized operations against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [10:0] ControlResult;
  logic [31:0] OperandA, OperandB;
  logic        Busy, Done;
  logic [31:0] Result;

  int checks   = 0;
  int failures = 0;
  logic [31:0] prev_result;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .Start(Start), .ControlResult(ControlResult),
    .OperandA(OperandA), .OperandB(OperandB),
    .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_cr(input logic [2:0] f3, input logic mul);
    logic [31:0] r;
    r = $urandom;
    return {r[10:7], mul, r[5:3], f3};
  endfunction

  // Architectural meaning of each op, computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and follow it cycle by cycle; operands are scrambled right
  // after accept, and optional Start pulses are thrown in while Busy.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit busy_pulses, input string name);
    int done_cyc = 0;
    int done_n   = 0;
    bit busy_ok  = 1;
    bit stable   = 1;
    logic [31:0] got = 32'hDEAD_BEEF;
    @(negedge clk);
    Start = 1'b1; ControlResult = mk_cr(f3, 1'b1); OperandA = a; OperandB = b;
    @(posedge clk);
    #1 Start = 1'b0;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        OperandA = $urandom; OperandB = $urandom;
        ControlResult = mk_cr(3'($urandom_range(0, 7)), 1'b1);
      end
      if (busy_pulses) Start = (cyc == 5 || cyc == 20);
      if (Done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = cyc;
        if (cyc == 33) got = Result;
      end
      if (!Busy) busy_ok = 0;
      if (cyc < 33 && Result !== prev_result) stable = 0;
    end
    Start = 1'b0;
    chk({name, " done_cycle"}, 32'(done_cyc), 32'd33);
    chk({name, " done_count"}, 32'(done_n), 32'd1);
    chk({name, " busy_held"}, 32'(busy_ok), 32'd1);
    chk({name, " result_stable"}, 32'(stable), 32'd1);
    chk({name, " result"}, got, exp);
    @(negedge clk);
    chk({name, " idle_c34"}, {30'b0, Busy, Done}, 32'd0);
    chk({name, " result_held"}, Result, exp);
    prev_result = exp;
  endtask

  initial begin
    int dn;
    bit busy_seen;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E};
    vecs[7]  = '{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002};
    vecs[8]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[9]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF};

    reset = 1'b1; Start = 1'b0; ControlResult = '0; OperandA = '0; OperandB = '0;
    prev_result = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy_done", {30'b0, Busy, Done}, 32'd0);
    chk("reset_result", Result, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, (i == 0), $sformatf("vec%0d", i));

    // Start without mulOp must be ignored.
    @(negedge clk);
    Start = 1'b1; ControlResult = mk_cr(3'd0, 1'b0); OperandA = 32'd9; OperandB = 32'd9;
    busy_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      Start = 1'b0;
      if (Busy || Done) busy_seen = 1;
    end
    chk("no_mulop_ignored", 32'(busy_seen), 32'd0);
    chk("no_mulop_result", Result, prev_result);

    run_op(3'd0, 32'd5, 32'd5, 32'h19, 1'b0, "mul_5x5");

    // Reset at cycle 10 of a DIV, with a simultaneous Start.
    @(negedge clk);
    Start = 1'b1; ControlResult = mk_cr(3'd4, 1'b1); OperandA = 32'd1000; OperandB = 32'd7;
    @(posedge clk);
    #1 Start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) @(negedge clk);
    reset = 1'b1; Start = 1'b1; ControlResult = mk_cr(3'd0, 1'b1);
    @(negedge clk);
    chk("rst_mid_busy_done", {30'b0, Busy, Done}, 32'd0);
    chk("rst_mid_result", Result, 32'h0);
    reset = 1'b0; Start = 1'b0;
    prev_result = 32'h0;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (Done || Busy) dn++;
    end
    chk("rst_no_done", 32'(dn), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 32'h0000_000C, 1'b0, "mul_3x4_after_rst");

    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(rf3, ra, rb, ref_model(rf3, ra, rb), (i % 5 == 0),
             $sformatf("rnd%0d f3=%0d a=%h b=%h", i, rf3, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
